// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD CMD-line response receiver.
// Consumed by cmd_response_rx_ctrl and cmd_crc7.
package sd_cmd_pkg;
  localparam int NCR_MAX_DEF   = 64;
  localparam int SHORT_LEN_DEF = 48;
  localparam int LONG_LEN_DEF  = 136;
  localparam int RESP_W        = 136;

  // x^7 + x^3 + 1
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_START,
    S_RECEIVE,
    S_REPORT
  } rx_state_e;
endpackage

// File: rtl/cmd_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0), one bit per enabled cycle, MSB first.
module cmd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       sd_clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);
  logic fb;
  assign fb = bit_in ^ crc[6];

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset)      crc <= '0;
    else if (clear)  crc <= '0;
    else if (enable) crc <= {crc[5:0], 1'b0} ^ ({7{fb}} & CRC7_POLY);
  end
endmodule

// File: rtl/cmd_response_rx_ctrl.sv
// SD command response receiver: start-bit hunt within NCR, 48/136-bit shift-in,
// end-bit check and optional CRC7 check (built only when CMD_RX_CRC7_EN is defined).
module cmd_response_rx_ctrl
  import sd_cmd_pkg::*;
#(
  parameter int NCR_MAX   = NCR_MAX_DEF,
  parameter int SHORT_LEN = SHORT_LEN_DEF,
  parameter int LONG_LEN  = LONG_LEN_DEF
) (
  input  logic              sd_clock,
  input  logic              reset,
  input  logic              start,
  input  logic              long_resp,
  input  logic              crc_skip,
  input  logic              abort,
  input  logic              cmd_in,
  output logic              busy,
  output logic              done,
  output logic [RESP_W-1:0] resp_data,
  output logic              timeout_err,
  output logic              end_err,
  output logic              crc_err
);
  localparam int TW = $clog2(NCR_MAX + 1);
  localparam int CW = $clog2(LONG_LEN + 1);

  rx_state_e state, state_nxt;
  logic          long_q;
  logic [TW-1:0] timer;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] last_idx;
  logic          accept, tmo_hit, last_bit;

  assign last_idx = long_q ? CW'(LONG_LEN - 1) : CW'(SHORT_LEN - 1);
  assign accept   = (state == S_IDLE) && start && !abort;
  assign tmo_hit  = (state == S_WAIT_START) && cmd_in && (timer == TW'(NCR_MAX - 1));
  assign last_bit = (state == S_RECEIVE) && (bit_cnt == last_idx);

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:       if (start) state_nxt = S_WAIT_START;
        S_WAIT_START: if (!cmd_in) state_nxt = S_RECEIVE;
                      else if (tmo_hit) state_nxt = S_REPORT;
        S_RECEIVE:    if (last_bit) state_nxt = S_REPORT;
        S_REPORT:     state_nxt = S_IDLE;
        default:      state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_REPORT);
  end

  // Datapath; an abort freezes everything so the partial frame stays visible.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      long_q      <= 1'b0;
      timer       <= '0;
      bit_cnt     <= '0;
      resp_data   <= '0;
      timeout_err <= 1'b0;
      end_err     <= 1'b0;
    end else if (accept) begin
      long_q      <= long_resp;
      timer       <= '0;
      bit_cnt     <= '0;
      resp_data   <= '0;
      timeout_err <= 1'b0;
      end_err     <= 1'b0;
    end else if (!abort) begin
      case (state)
        S_WAIT_START: begin
          if (!cmd_in) begin
            resp_data <= {resp_data[RESP_W-2:0], cmd_in};
            bit_cnt   <= CW'(1);
          end else begin
            timer <= timer + TW'(1);
            if (tmo_hit) timeout_err <= 1'b1;
          end
        end
        S_RECEIVE: begin
          resp_data <= {resp_data[RESP_W-2:0], cmd_in};
          bit_cnt   <= bit_cnt + CW'(1);
          if (last_bit) end_err <= !cmd_in;
        end
        default: ;
      endcase
    end
  end

`ifdef CMD_RX_CRC7_EN
  logic       skip_q;
  logic       crc_en;
  logic [6:0] crc_calc;

  // Short frames cover indices 0..len-9 (start bit included); long frames start at 8.
  always_comb begin
    crc_en = 1'b0;
    if (!abort) begin
      if (state == S_WAIT_START)
        crc_en = !cmd_in && !long_q;
      else if (state == S_RECEIVE)
        crc_en = long_q ? (bit_cnt >= CW'(8) && bit_cnt <= CW'(LONG_LEN - 9))
                        : (bit_cnt <= CW'(SHORT_LEN - 9));
    end
  end

  cmd_crc7 u_crc7 (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clear    (accept),
    .enable   (crc_en),
    .bit_in   (cmd_in),
    .crc      (crc_calc)
  );

  // On the end-bit edge the received CRC sits in resp_data[6:0].
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      skip_q  <= 1'b0;
      crc_err <= 1'b0;
    end else if (accept) begin
      skip_q  <= crc_skip;
      crc_err <= 1'b0;
    end else if (!abort && last_bit) begin
      crc_err <= (crc_calc != resp_data[6:0]) && !skip_q;
    end
  end
`else
  assign crc_err = 1'b0;
`endif
endmodule

// File: tb/tb_cmd_response_rx_ctrl.sv
// Scoreboard bench for cmd_response_rx_ctrl: directed cases then randomized frames.
module tb_cmd_response_rx_ctrl;
  logic         sd_clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0, long_resp = 1'b0, crc_skip = 1'b0, abort = 1'b0, cmd_in = 1'b1;
  logic         busy, done, timeout_err, end_err, crc_err;
  logic [135:0] resp_data;

  cmd_response_rx_ctrl dut (
    .sd_clock    (sd_clock),
    .reset       (reset),
    .start       (start),
    .long_resp   (long_resp),
    .crc_skip    (crc_skip),
    .abort       (abort),
    .cmd_in      (cmd_in),
    .busy        (busy),
    .done        (done),
    .resp_data   (resp_data),
    .timeout_err (timeout_err),
    .end_err     (end_err),
    .crc_err     (crc_err)
  );

  always #5 sd_clock = ~sd_clock;

  int cyc = 0;
  always @(posedge sd_clock) cyc <= cyc + 1;

  typedef struct {
    logic [135:0] data;
    logic         tmo, endb, crc;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, expv);
    end
  endtask

  // Reference CRC7: long division by x^7+x^3+1 over frame indices lo..hi (index 0 = first bit sent).
  function automatic logic [6:0] crc7m(input logic [135:0] fr, input int len, input int lo, input int hi);
    logic [6:0] c = '0;
    logic       fb;
    for (int i = lo; i <= hi; i++) begin
      fb = fr[len-1-i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [135:0] mk_frame(input bit lng);
    logic [135:0] fr;
    int len = lng ? 136 : 48;
    fr = {$urandom, $urandom, $urandom, $urandom, $urandom};
    if (!lng) fr[135:48] = '0;
    fr[len-1] = 1'b0;
    fr[0]     = 1'b1;
    fr[7:1]   = crc7m(fr, len, lng ? 8 : 0, lng ? 127 : 39);
    return fr;
  endfunction

  always @(negedge sd_clock) begin
    if (reset && done) begin
      exp_t e;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("done_cycle",  136'(cyc), 136'(e.cyc));
        chk("resp_data",   resp_data, e.data);
        chk("timeout_err", 136'(timeout_err), 136'(e.tmo));
        chk("end_err",     136'(end_err), 136'(e.endb));
        chk("crc_err",     136'(crc_err), 136'(e.crc));
      end
    end
  end

  // Issue start, wait d high cycles, then send the frame MSB first.
  task automatic send(input logic [135:0] fr, input bit lng, input bit skp, input int d);
    int   len = lng ? 136 : 48;
    exp_t e;
    start = 1'b1; long_resp = lng; crc_skip = skp; cmd_in = 1'b1;
    @(posedge sd_clock); #1;
    start = 1'b0;
    chk("busy_after_start", 136'(busy), 136'(1));
    e.data = fr;
    e.tmo  = 1'b0;
    e.endb = ~fr[0];
`ifdef CMD_RX_CRC7_EN
    e.crc  = !skp && (crc7m(fr, len, lng ? 8 : 0, lng ? 127 : 39) != fr[7:1]);
`else
    e.crc  = 1'b0;
`endif
    e.cyc  = cyc + d + len;
    q.push_back(e);
    for (int i = 0; i < d; i++) begin cmd_in = 1'b1; @(posedge sd_clock); #1; end
    for (int i = 0; i < len; i++) begin cmd_in = fr[len-1-i]; @(posedge sd_clock); #1; end
    cmd_in = 1'b1;
    @(posedge sd_clock); #1;
  endtask

  task automatic send_timeout();
    exp_t e;
    start = 1'b1; long_resp = 1'b0; crc_skip = 1'b0; cmd_in = 1'b1;
    @(posedge sd_clock); #1;
    start = 1'b0;
    e.data = '0; e.tmo = 1'b1; e.endb = 1'b0; e.crc = 1'b0; e.cyc = cyc + 64;
    q.push_back(e);
    repeat (65) @(posedge sd_clock);
    #1;
  endtask

  // Start a short frame and leave it mid-RECEIVE after 20 bits.
  task automatic partial_frame();
    start = 1'b1; long_resp = 1'b0; crc_skip = 1'b0; cmd_in = 1'b1;
    @(posedge sd_clock); #1;
    start = 1'b0; cmd_in = 1'b0;
    @(posedge sd_clock); #1;
    for (int i = 0; i < 20; i++) begin cmd_in = 1'($urandom); @(posedge sd_clock); #1; end
  endtask

  logic [135:0] f;
  initial begin
    repeat (3) @(posedge sd_clock);
    #1;
    chk("rst_busy", 136'(busy), 136'(0));
    chk("rst_done", 136'(done), 136'(0));
    chk("rst_resp", resp_data, '0);
    chk("rst_tmo",  136'(timeout_err), 136'(0));
    chk("rst_end",  136'(end_err), 136'(0));
    chk("rst_crc",  136'(crc_err), 136'(0));
    reset = 1'b1;
    @(posedge sd_clock); #1;

    f = 136'h400000000095;
    send(f, 0, 0, 0);
    f = f ^ (136'(1) << 20);
    send(f, 0, 0, 0);
    send(f, 0, 1, 0);
    send(136'h400000000094, 0, 0, 2);
    send_timeout();
    send(mk_frame(0), 0, 0, 63);
    send(mk_frame(1), 1, 0, 5);

    partial_frame();
    abort = 1'b1;
    @(posedge sd_clock); #1;
    abort = 1'b0; cmd_in = 1'b1;
    chk("abort_busy", 136'(busy), 136'(0));
    repeat (40) @(posedge sd_clock);
    #1;

    start = 1'b1; abort = 1'b1;
    @(posedge sd_clock); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 136'(busy), 136'(0));

    partial_frame();
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 136'(busy), 136'(0));
    chk("mid_rst_done", 136'(done), 136'(0));
    chk("mid_rst_resp", resp_data, '0);
    chk("mid_rst_tmo",  136'(timeout_err), 136'(0));
    chk("mid_rst_end",  136'(end_err), 136'(0));
    chk("mid_rst_crc",  136'(crc_err), 136'(0));
    cmd_in = 1'b1;
    @(posedge sd_clock); #1;
    reset = 1'b1;
    @(posedge sd_clock); #1;
    send(136'h400000000095, 0, 0, 1);

    for (int n = 0; n < 25; n++) begin
      bit lng = 1'($urandom);
      bit skp = 1'($urandom);
      int len = lng ? 136 : 48;
      int mode = $urandom_range(0, 3);
      f = mk_frame(lng);
      if (mode == 1) f[$urandom_range(len-2, 1)] ^= 1'b1;
      else if (mode == 2) f[0] = 1'b0;
      send(f, lng, skp, $urandom_range(0, 63));
    end

    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge sd_clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_done pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
